// File: rtl/fp_pkg.sv
// ============================================================================
// Module : fp_pkg
// Brief  : float32 field layout, FIFO entry format and accumulator FSM states.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package fp_pkg;

  localparam int FP_EXP_W    = 8;
  localparam int FP_MAN_W    = 23;
  localparam int FP_W        = 1 + FP_EXP_W + FP_MAN_W;
  localparam int FP_SIGN_BIT = FP_W - 1;

  localparam logic [FP_W-1:0] FP_ZERO = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_RELEASE = 2'd2,
    ST_EMIT    = 2'd3
  } fsm_state_t;

  typedef struct packed {
    logic            last;
    logic            neg;
    logic [FP_W-1:0] data;
  } entry_t;

  function automatic logic [FP_W-1:0] fp_negate_if(input logic [FP_W-1:0] x,
                                                   input logic            neg);
    return {x[FP_SIGN_BIT] ^ neg, x[FP_SIGN_BIT-1:0]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/fp_sync_fifo.sv
// ============================================================================
// Module : fp_sync_fifo
// Brief  : Single-clock FIFO with full/empty flags; read data is show-ahead.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module fp_sync_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q;
  logic [AW:0]      rptr_q;
  logic             do_push_w;
  logic             do_pop_w;

  assign do_push_w = push_i && !full_o;
  assign do_pop_w  = pop_i && !empty_o;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty_o   = (wptr_q == rptr_q);
  assign full_o    = (wptr_q[AW] != rptr_q[AW]) &&
                     (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign rd_data_o = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push_w) wptr_q <= wptr_q + 1'b1;
      if (do_pop_w)  rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push_w) mem_q[wptr_q[AW-1:0]] <= wr_data_i;
  end

endmodule

`default_nettype wire

// File: rtl/fp_accum_initiator.sv
// ============================================================================
// Module : fp_accum_initiator
// Brief  : Buffers float32 elements and sums each packet through an external
//          add/sub unit. Optional issue/release timeout: FP_CI_TIMEOUT_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module fp_accum_initiator
  import fp_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [FP_W-1:0] s_data,
  input  logic            s_neg,
  input  logic            s_last,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [FP_W-1:0] m_data,
  output logic            ci_enable,
  output logic [FP_W-1:0] ci_dataa,
  output logic [FP_W-1:0] ci_datab,
  input  logic            ci_done,
  input  logic [FP_W-1:0] ci_result,
  output logic            busy
`ifdef FP_CI_TIMEOUT_EN
  ,
  output logic            err
`endif
);

  fsm_state_t      state_q, state_d;
  logic [FP_W-1:0] acc_q, acc_d;
  logic            last_q, last_d;
  logic            en_q, en_d;
  logic [FP_W-1:0] dataa_q, dataa_d;
  logic [FP_W-1:0] datab_q, datab_d;
  logic            mvalid_q, mvalid_d;

  entry_t          wr_entry_w;
  entry_t          rd_entry_w;
  logic            fifo_full_w;
  logic            fifo_empty_w;
  logic            pop_w;
  logic            timeout_w;

  assign wr_entry_w = '{last: s_last, neg: s_neg, data: s_data};

  fp_sync_fifo #(
    .WIDTH($bits(entry_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push_i    (s_valid),
    .wr_data_i (wr_entry_w),
    .pop_i     (pop_w),
    .rd_data_o (rd_entry_w),
    .full_o    (fifo_full_w),
    .empty_o   (fifo_empty_w)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    last_d  = last_q;
    en_d    = en_q;
    dataa_d = dataa_q;
    datab_d = datab_q;
    pop_w   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // A unit still holding done (e.g. after reset) must drop it before we re-enable.
        if (!fifo_empty_w && !ci_done) begin
          pop_w   = 1'b1;
          dataa_d = acc_q;
          datab_d = fp_negate_if(rd_entry_w.data, rd_entry_w.neg);
          last_d  = rd_entry_w.last;
          en_d    = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (ci_done) begin
          acc_d   = ci_result;
          en_d    = 1'b0;
          state_d = ST_RELEASE;
        end else if (timeout_w) begin
          en_d    = 1'b0;
          state_d = last_q ? ST_EMIT : ST_IDLE;
        end
      end
      ST_RELEASE: begin
        if (!ci_done || timeout_w) begin
          state_d = last_q ? ST_EMIT : ST_IDLE;
        end
      end
      ST_EMIT: begin
        if (m_ready) begin
          acc_d   = FP_ZERO;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    mvalid_d = (state_d == ST_EMIT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      acc_q    <= FP_ZERO;
      last_q   <= 1'b0;
      en_q     <= 1'b0;
      dataa_q  <= FP_ZERO;
      datab_q  <= FP_ZERO;
      mvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      last_q   <= last_d;
      en_q     <= en_d;
      dataa_q  <= dataa_d;
      datab_q  <= datab_d;
      mvalid_q <= mvalid_d;
    end
  end

`ifdef FP_CI_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);

  logic [TMO_W-1:0] tmo_cnt_q;
  logic             err_q;
  logic             waiting_w;

  assign waiting_w = (state_q == ST_ISSUE) || (state_q == ST_RELEASE);
  assign timeout_w = waiting_w && (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      if (state_d != state_q) tmo_cnt_q <= '0;
      else if (waiting_w)     tmo_cnt_q <= tmo_cnt_q + 1'b1;
      // Flag only when the timeout branch actually wins over the unit handshake.
      if (timeout_w && ((state_q == ST_ISSUE) ? !ci_done : ci_done)) err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign timeout_w = 1'b0;
`endif

  assign s_ready   = !fifo_full_w;
  assign busy      = (state_q != ST_IDLE) || !fifo_empty_w;
  assign m_valid   = mvalid_q;
  assign m_data    = acc_q;
  assign ci_enable = en_q;
  assign ci_dataa  = dataa_q;
  assign ci_datab  = datab_q;

endmodule

`default_nettype wire

// File: tb/tb_fp_accum_initiator.sv
// ============================================================================
// Module : tb_fp_accum_initiator
// Brief  : Directed scoreboard bench with a behavioural float add/sub unit.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_fp_accum_initiator;

  localparam int TB_TMO = 20;

  logic        clk = 1'b0;
  logic        reset;
  logic        s_valid, s_ready, s_neg, s_last;
  logic [31:0] s_data;
  logic        m_valid, m_ready;
  logic [31:0] m_data;
  logic        ci_enable, ci_done;
  logic [31:0] ci_dataa, ci_datab, ci_result;
  logic        busy;
`ifdef FP_CI_TIMEOUT_EN
  logic        err;
`endif

  int          n_pass  = 0;
  int          n_total = 0;
  int          cyc     = 0;

  logic [31:0] sb_q[$];
  int          rise_cyc_q[$];
  logic [31:0] rise_a_q[$];
  logic [31:0] rise_b_q[$];
  int          reissue_viol = 0;

  int          u_hold = 0;
  bit          u_dead = 1'b0;
  int          u_cnt  = 0;

  logic        prev_en  = 1'b0;
  logic        prev_mv  = 1'b0;
  logic        prev_acc = 1'b0;
  logic [31:0] prev_md  = '0;

  fp_accum_initiator #(
    .FIFO_DEPTH     (8),
    .TIMEOUT_CYCLES (TB_TMO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_neg     (s_neg),
    .s_last    (s_last),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .ci_enable (ci_enable),
    .ci_dataa  (ci_dataa),
    .ci_datab  (ci_datab),
    .ci_done   (ci_done),
    .ci_result (ci_result),
    .busy      (busy)
`ifdef FP_CI_TIMEOUT_EN
    ,
    .err       (err)
`endif
  );

  always #5 clk = ~clk;

  function automatic real f2r(input logic [31:0] f);
    logic [10:0] e;
    if (f[30:23] == 8'd0) return 0.0;
    e = 11'(f[30:23]) - 11'd127 + 11'd1023;
    return $bitstoreal({f[31], e, f[22:0], 29'd0});
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [10:0] e;
    if (r == 0.0) return 32'h0;
    d = $realtobits(r);
    e = d[62:52] - 11'd1023 + 11'd127;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  // Add/sub unit: done one cycle after sampling enable, held u_hold extra cycles.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset && cyc == 0) begin
      ci_done   <= 1'b0;
      ci_result <= '0;
      u_cnt     <= 0;
    end else if (ci_enable && !u_dead) begin
      ci_done   <= 1'b1;
      ci_result <= r2f(f2r(ci_dataa) + f2r(ci_datab));
      u_cnt     <= u_hold;
    end else if (ci_done && u_cnt > 0) begin
      u_cnt <= u_cnt - 1;
    end else begin
      ci_done <= 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (ci_enable && !prev_en) begin
        rise_cyc_q.push_back(cyc);
        rise_a_q.push_back(ci_dataa);
        rise_b_q.push_back(ci_datab);
        if (ci_done) reissue_viol <= reissue_viol + 1;
      end
      if (prev_mv && !prev_acc) begin
        check("m_valid_hold", {31'd0, m_valid}, 32'd1);
        check("m_data_stable", m_data, prev_md);
      end
      if (m_valid && m_ready) begin
        if (sb_q.size() == 0) check("sb_unexpected_sum", m_data, 32'hxxxx_xxxx);
        else check("sum", m_data, sb_q.pop_front());
      end
    end
    prev_en  <= ci_enable;
    prev_mv  <= m_valid;
    prev_acc <= m_valid && m_ready;
    prev_md  <= m_data;
  end

  task automatic push(input logic [31:0] d, input logic n, input logic l);
    int k;
    @(negedge clk);
    s_valid = 1'b1; s_data = d; s_neg = n; s_last = l;
    k = 0;
    while (!s_ready && k < 300) begin @(negedge clk); k++; end
    if (!s_ready) check("push_ready_wait", {31'd0, s_ready}, 32'd1);
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int k;
    k = 0;
    while ((sb_q.size() != 0 || busy || m_valid) && k < 1000) begin @(negedge clk); k++; end
    check(tag, {31'd0, k < 1000}, 32'd1);
  endtask

  task automatic clear_mon();
    rise_cyc_q.delete(); rise_a_q.delete(); rise_b_q.delete();
  endtask

  initial begin
    int k;
    reset = 1'b1; s_valid = 1'b0; s_data = '0; s_neg = 1'b0; s_last = 1'b0; m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_s_ready",   {31'd0, s_ready},   32'd1);
    check("rst_m_valid",   {31'd0, m_valid},   32'd0);
    check("rst_m_data",    m_data,             32'd0);
    check("rst_ci_enable", {31'd0, ci_enable}, 32'd0);
    check("rst_ci_dataa",  ci_dataa,           32'd0);
    check("rst_ci_datab",  ci_datab,           32'd0);
    check("rst_busy",      {31'd0, busy},      32'd0);
`ifdef FP_CI_TIMEOUT_EN
    check("rst_err",       {31'd0, err},       32'd0);
`endif
    @(negedge clk); reset = 1'b0;

    // 1.0 + 2.0, elements back to back
    clear_mon();
    sb_q.push_back(32'h4040_0000);
    push(32'h3F80_0000, 1'b0, 1'b0);
    push(32'h4000_0000, 1'b0, 1'b1);
    drain("p1_drain");
    check("p1_issue_count", rise_cyc_q.size(), 32'd2);
    if (rise_cyc_q.size() >= 2) begin
      check("p1_elem_cycles", 32'(rise_cyc_q[1] - rise_cyc_q[0]), 32'd5);
      check("p1_dataa0", rise_a_q[0], 32'h0000_0000);
      check("p1_datab0", rise_b_q[0], 32'h3F80_0000);
      check("p1_dataa1", rise_a_q[1], 32'h3F80_0000);
    end

    // 3.0 - 0.5
    clear_mon();
    sb_q.push_back(32'h4020_0000);
    push(32'h4040_0000, 1'b0, 1'b0);
    push(32'h3F00_0000, 1'b1, 1'b1);
    drain("p2_drain");
    check("p2_issue_count", rise_b_q.size(), 32'd2);
    if (rise_b_q.size() >= 2) check("p2_datab1", rise_b_q[1], 32'hBF00_0000);

    // {0.0} held unaccepted while eight 1.0 elements fill the FIFO
    m_ready = 1'b0;
    sb_q.push_back(32'h0000_0000);
    push(32'h0000_0000, 1'b0, 1'b1);
    k = 0;
    while (!m_valid && k < 50) begin @(negedge clk); k++; end
    check("p3_m_valid", {31'd0, m_valid}, 32'd1);
    sb_q.push_back(32'h4100_0000);
    for (int i = 0; i < 8; i++) begin
      push(32'h3F80_0000, 1'b0, i == 7);
      check($sformatf("p4_s_ready_%0d", i), {31'd0, s_ready}, {31'd0, i < 7});
    end
    check("p4_busy", {31'd0, busy}, 32'd1);
    repeat (10) @(negedge clk);
    check("p3_held_valid", {31'd0, m_valid}, 32'd1);
    check("p3_held_data", m_data, 32'h0000_0000);
    m_ready = 1'b1;
    drain("p4_drain");

    // Unit holds done three extra cycles after enable falls
    clear_mon();
    u_hold = 3;
    sb_q.push_back(32'h4000_0000);
    push(32'h3F80_0000, 1'b0, 1'b0);
    push(32'h3F80_0000, 1'b0, 1'b1);
    drain("p5_drain");
    check("p5_issue_count", rise_cyc_q.size(), 32'd2);
    if (rise_cyc_q.size() >= 2) check("p5_elem_cycles", 32'(rise_cyc_q[1] - rise_cyc_q[0]), 32'd8);
    check("reissue_while_done", reissue_viol, 32'd0);
    u_hold = 0;

    // Reset while an operation is in flight
    push(32'h3F80_0000, 1'b0, 1'b0);
    k = 0;
    while (!ci_enable && k < 50) begin @(negedge clk); k++; end
    check("p6_in_issue", {31'd0, ci_enable}, 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    check("p6_rst_enable", {31'd0, ci_enable}, 32'd0);
    check("p6_rst_busy",   {31'd0, busy},      32'd0);
    check("p6_rst_ready",  {31'd0, s_ready},   32'd1);
    check("p6_rst_mdata",  m_data,             32'd0);
    @(negedge clk); reset = 1'b0;
    sb_q.push_back(32'h4000_0000);
    push(32'h4000_0000, 1'b0, 1'b1);
    drain("p6_drain");
    check("reissue_after_rst", reissue_viol, 32'd0);

`ifdef FP_CI_TIMEOUT_EN
    // Unit never answers: element dropped, sum emitted unchanged
    clear_mon();
    u_dead = 1'b1;
    sb_q.push_back(32'h0000_0000);
    push(32'h3F80_0000, 1'b0, 1'b1);
    k = 0;
    while (!err && k < 200) begin @(negedge clk); k++; end
    check("tmo_err_set", {31'd0, err}, 32'd1);
    if (rise_cyc_q.size() >= 1) check("tmo_cycles", 32'(cyc - rise_cyc_q[0]), 32'(TB_TMO));
    drain("tmo_drain");
    check("tmo_err_sticky", {31'd0, err}, 32'd1);
    u_dead = 1'b0;
`endif

    check("sb_empty", sb_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/fp_accum_initiator.md
# fp_accum_initiator

Initiator side of the single-precision custom-instruction handshake (`dataa`/`datab`/`enable`/`done`/`result`). It buffers a stream of IEEE-754 float32 operands, issues one add/sub operation at a time to an external float add/sub unit, and folds each result into a running accumulator. At the end of each packet it emits the sum. It sits between the host-side data source and the existing float add/sub unit, so packet sums need no processor involvement.

## Interface
- `FIFO_DEPTH`, 8: input buffer entries, power of two, ≥2.
- `TIMEOUT_CYCLES`, 255: maximum ISSUE/RELEASE wait when the timeout is compiled in.

- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `s_valid`  in  1  input element valid.
- `s_ready`  out  1  FIFO not full.
- `s_data`  in  32  float32 element.
- `s_neg`  in  1  subtract this element (sign of `s_data[31]` flipped).
- `s_last`  in  1  final element of packet.
- `m_valid`  out  1  packet sum valid.
- `m_ready`  in  1  sum accepted.
- `m_data`  out  32  packet sum.
- `ci_enable`  out  1  operation request to the add/sub unit.
- `ci_dataa`  out  32  accumulator operand.
- `ci_datab`  out  32  element operand, sign-adjusted.
- `ci_done`  in  1  unit completion.
- `ci_result`  in  32  unit result, valid while `ci_done`=1.
- `busy`  out  1  FSM not in IDLE, or FIFO non-empty.
- `err`  out  1  sticky timeout flag. Present only with `FP_CI_TIMEOUT_EN`.

## Operation
- FIFO entry = {last, neg, data} (34 bits). An entry is written when `s_valid && s_ready`.
- Accumulator `acc` (32 bits) is 0x00000000 at reset and after every EMIT.
- FSM states: IDLE, ISSUE, RELEASE, EMIT.
  - IDLE: if FIFO is non-empty, pop; latch `ci_dataa`=acc, `ci_datab`={data[31]^neg, data[30:0]}, last flag; go to ISSUE.
  - ISSUE: `ci_enable`=1 with operands held stable. When `ci_done`=1: acc←`ci_result`, go to RELEASE.
  - RELEASE: `ci_enable`=0. Wait until `ci_done`=0, because the unit holds `done` one cycle past enable. Then go to EMIT if last was set, else to IDLE.
  - EMIT: `m_valid`=1, `m_data`=acc. On `m_ready`: acc←0, go to IDLE.
- The first element of a packet is issued as 0 ± x. The unit's zero bypass returns x exactly.
- The FIFO may be written in any state, including when a pop and a push happen in the same cycle.
- `s_ready` = not full. A full FIFO with a simultaneous pop still reports not-ready that cycle (no combinational path from the pop).
- Reset mid-operation: FSM goes to IDLE, FIFO is emptied, acc=0, `ci_enable` is low from the next cycle. Any in-flight unit result is ignored.

## Timing
- Reset values: `s_ready`=1, `m_valid`=0, `m_data`=0, `ci_enable`=0, `ci_dataa`=0, `ci_datab`=0, `busy`=0, `err`=0.
- All outputs are registered except `s_ready` and `busy`, which are decoded from registered state.
- With a unit that raises `done` one cycle after sampling `enable`, each element takes 5 cycles: IDLE 1, ISSUE 2, RELEASE 2.
- `ci_enable` is never reasserted while `ci_done`=1.
- `m_valid` holds until `m_ready`. `m_data` is stable while `m_valid`=1.

## Configuration
- `FP_CI_TIMEOUT_EN` defined:
  - A counter runs in ISSUE and RELEASE and clears on every state change.
  - When it reaches `TIMEOUT_CYCLES`: `err`←1 (sticky until reset), acc is left unchanged, the FSM drops the element and goes to EMIT if last was set, else to IDLE.
- `FP_CI_TIMEOUT_EN` undefined: no counter and no `err` port; the FSM waits indefinitely.

## Structure
- Shared package `fp_pkg`:
  - float32 field widths and constants: `FP_ZERO`=32'h0, sign bit index 31.
  - FSM state enum.
- Sub-module `fp_sync_fifo` (parameterised width and depth, full/empty flags) holds the input buffer.

## Test plan
- Packet {1.0 0x3F800000, 2.0 0x40000000 last} → `m_data`=0x40400000 (3.0); 5 cycles per element measured against a 1-cycle unit model.
- Packet {3.0, 0.5 with `s_neg`=1 last} → `m_data`=0x40200000 (2.5); `ci_datab`=0xBF000000 on the second issue.
- Single-element packet {0.0 last} → `m_data`=0x00000000. Then back-to-back packets with `m_ready` held low 10 cycles → `m_valid` and `m_data` stable, second packet buffered, `s_ready` drops after `FIFO_DEPTH` writes.
- Unit model holding `done` 3 cycles after `enable` falls → no `ci_enable` rise until `done`=0.
- Reset asserted during ISSUE → next cycle `ci_enable`=0, `busy`=0, FIFO empty; next packet sums from 0.
- With `FP_CI_TIMEOUT_EN` and a unit that never responds → `err`=1 exactly `TIMEOUT_CYCLES` cycles after ISSUE entry; a last-flagged element still yields `m_valid`.
